// File: rtl/sram_array_ctrl.sv
// Precharge -> wordline -> write-drive/sense sequencer for a small 6T SRAM array.
// Array-facing strobes are decoded from the state, so they never overlap and drop the cycle after reset.
module sram_array_ctrl #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 4,
    parameter int PRE_CYC = 1,
    parameter int WL_CYC  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W-1:0]        bl_sense,
    output logic                     bl_pre,
    output logic [(2**ADDR_W)-1:0]   wl,
    output logic                     wr_drv,
    output logic [DATA_W-1:0]        bl_wdata,
    output logic                     sae,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     ack
);

    localparam int CNT_MAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] WL_LAST  = CNT_W'(WL_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields are captured only on acceptance, so changes while busy have no effect.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        bl_pre   = 1'b0;
        wl       = '0;
        wr_drv   = 1'b0;
        bl_wdata = '0;
        sae      = 1'b0;
        busy     = 1'b0;
        ack      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            PRE: begin
                busy   = 1'b1;
                bl_pre = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = ACC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACC: begin
                busy         = 1'b1;
                wl[addr_q]   = 1'b1;
                if (we_q) begin
                    wr_drv   = 1'b1;
                    bl_wdata = wdata_q;
                end else if (cnt_q == WL_LAST) begin
                    // Sense only once the bitline split has had the full wordline window to develop.
                    sae     = 1'b1;
                    rdata_d = bl_sense;
                end
                if (cnt_q == WL_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy    = 1'b1;
                ack     = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench for sram_array_ctrl: default timing instance (a) and a PRE_CYC=3/WL_CYC=1 instance (b).
// Output vector order: {bl_pre, wl[3:0], wr_drv, bl_wdata[3:0], sae, busy, ack}.
module tb_sram_array_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [1:0] addr_a, addr_b;
    logic [3:0] wdata_a, wdata_b, sense_a, sense_b;

    logic       bl_pre_a, wr_drv_a, sae_a, busy_a, ack_a;
    logic       bl_pre_b, wr_drv_b, sae_b, busy_b, ack_b;
    logic [3:0] wl_a, bl_wdata_a, rdata_a, wl_b, bl_wdata_b, rdata_b;
    logic [12:0] obs_a, obs_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_array_ctrl #(.ADDR_W(2), .DATA_W(4), .PRE_CYC(1), .WL_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .bl_sense(sense_a), .bl_pre(bl_pre_a), .wl(wl_a), .wr_drv(wr_drv_a),
        .bl_wdata(bl_wdata_a), .sae(sae_a), .rdata(rdata_a), .busy(busy_a), .ack(ack_a)
    );

    sram_array_ctrl #(.ADDR_W(2), .DATA_W(4), .PRE_CYC(3), .WL_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .bl_sense(sense_b), .bl_pre(bl_pre_b), .wl(wl_b), .wr_drv(wr_drv_b),
        .bl_wdata(bl_wdata_b), .sae(sae_b), .rdata(rdata_b), .busy(busy_b), .ack(ack_b)
    );

    assign obs_a = {bl_pre_a, wl_a, wr_drv_a, bl_wdata_a, sae_a, busy_a, ack_a};
    assign obs_b = {bl_pre_b, wl_b, wr_drv_b, bl_wdata_b, sae_b, busy_b, ack_b};

    // Array-safety invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (!((bl_pre_a & |wl_a) == 1'b0 && (wr_drv_a & sae_a) == 1'b0 &&
                  $countones(wl_a) <= 1 && (!(wr_drv_a | sae_a) || (|wl_a)))) begin
                $display("[TB] FAIL invariant_a: obs=%b required no overlap", obs_a);
                n_bad++;
            end
            n_cmp++;
            if (!((bl_pre_b & |wl_b) == 1'b0 && (wr_drv_b & sae_b) == 1'b0 &&
                  $countones(wl_b) <= 1 && (!(wr_drv_b | sae_b) || (|wl_b)))) begin
                $display("[TB] FAIL invariant_b: obs=%b required no overlap", obs_b);
                n_bad++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 1'b1; we_a = 1'b1; addr_a = 2'd2; wdata_a = 4'hF; sense_a = 4'hF;
        req_b = 1'b1; we_b = 1'b0; addr_b = 2'd1; wdata_b = 4'hF; sense_b = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (obs_a !== 13'b0) begin
                $display("[TB] FAIL reset_obs_a: got %b expected %b", obs_a, 13'b0); n_bad++;
            end
            n_cmp++;
            if (rdata_a !== 4'h0) begin
                $display("[TB] FAIL reset_rdata_a: got %h expected 0", rdata_a); n_bad++;
            end
            n_cmp++;
            if (obs_b !== 13'b0) begin
                $display("[TB] FAIL reset_obs_b: got %b expected %b", obs_b, 13'b0); n_bad++;
            end
        end
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
        step();
        n_cmp++;
        if (obs_a !== 13'b0) begin
            $display("[TB] FAIL post_reset_idle: got %b expected %b", obs_a, 13'b0); n_bad++;
        end
    endtask

    task automatic test_write();
        logic [12:0] exp_v [5];
        exp_v = '{13'b1_0000_0_0000_0_1_0, 13'b0_0100_1_1010_0_1_0, 13'b0_0100_1_1010_0_1_0,
                  13'b0_0000_0_0000_0_1_1, 13'b0_0000_0_0000_0_0_0};
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd2; wdata_a = 4'hA;
        for (int i = 0; i < 5; i++) begin
            step();
            req_a = 1'b0; wdata_a = 4'h0;
            n_cmp++;
            if (obs_a !== exp_v[i]) begin
                $display("[TB] FAIL write_c%0d: got %b expected %b", i + 1, obs_a, exp_v[i]); n_bad++;
            end
        end
    endtask

    task automatic test_read();
        logic [12:0] exp_v [5];
        exp_v = '{13'b1_0000_0_0000_0_1_0, 13'b0_0010_0_0000_0_1_0, 13'b0_0010_0_0000_1_1_0,
                  13'b0_0000_0_0000_0_1_1, 13'b0_0000_0_0000_0_0_0};
        req_a = 1'b1; we_a = 1'b0; addr_a = 2'd1; sense_a = 4'h5;
        for (int i = 0; i < 5; i++) begin
            step();
            req_a = 1'b0;
            n_cmp++;
            if (obs_a !== exp_v[i]) begin
                $display("[TB] FAIL read_c%0d: got %b expected %b", i + 1, obs_a, exp_v[i]); n_bad++;
            end
            if (i == 2) begin
                n_cmp++;
                if (rdata_a !== 4'h0) begin
                    $display("[TB] FAIL read_rdata_early: got %h expected 0", rdata_a); n_bad++;
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (rdata_a !== 4'h5) begin
                    $display("[TB] FAIL read_rdata: got %h expected 5", rdata_a); n_bad++;
                end
            end
        end
        // A later write must leave the registered read data alone.
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 4'h3; sense_a = 4'hA;
        for (int i = 0; i < 5; i++) begin
            step();
            req_a = 1'b0;
        end
        n_cmp++;
        if (rdata_a !== 4'h5) begin
            $display("[TB] FAIL rdata_hold: got %h expected 5", rdata_a); n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_v [11];
        exp_v = '{13'b1_0000_0_0000_0_1_0, 13'b0_1000_1_0110_0_1_0, 13'b0_1000_1_0110_0_1_0,
                  13'b0_0000_0_0000_0_1_1, 13'b0_0000_0_0000_0_0_0, 13'b1_0000_0_0000_0_1_0,
                  13'b0_0001_1_1001_0_1_0, 13'b0_0001_1_1001_0_1_0, 13'b0_0000_0_0000_0_1_1,
                  13'b0_0000_0_0000_0_0_0, 13'b0_0000_0_0000_0_0_0};
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd3; wdata_a = 4'h6;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i + 1 == 2) begin
                addr_a = 2'd0; wdata_a = 4'h9;
            end
            if (i + 1 == 10) req_a = 1'b0;
            n_cmp++;
            if (obs_a !== exp_v[i]) begin
                $display("[TB] FAIL held_req_c%0d: got %b expected %b", i + 1, obs_a, exp_v[i]); n_bad++;
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [12:0] exp_v [5];
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd2; wdata_a = 4'h5;
        step();
        req_a = 1'b0;
        n_cmp++;
        if (obs_a !== 13'b1_0000_0_0000_0_1_0) begin
            $display("[TB] FAIL midop_pre: got %b expected %b", obs_a, 13'b1_0000_0_0000_0_1_0); n_bad++;
        end
        step();
        n_cmp++;
        if (obs_a !== 13'b0_0100_1_0101_0_1_0) begin
            $display("[TB] FAIL midop_acc: got %b expected %b", obs_a, 13'b0_0100_1_0101_0_1_0); n_bad++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (obs_a !== 13'b0) begin
            $display("[TB] FAIL midop_abort: got %b expected %b", obs_a, 13'b0); n_bad++;
        end
        n_cmp++;
        if (rdata_a !== 4'h0) begin
            $display("[TB] FAIL midop_rdata: got %h expected 0", rdata_a); n_bad++;
        end
        step();
        n_cmp++;
        if (obs_a !== 13'b0) begin
            $display("[TB] FAIL midop_no_ack: got %b expected %b", obs_a, 13'b0); n_bad++;
        end
        exp_v = '{13'b1_0000_0_0000_0_1_0, 13'b0_1000_0_0000_0_1_0, 13'b0_1000_0_0000_1_1_0,
                  13'b0_0000_0_0000_0_1_1, 13'b0_0000_0_0000_0_0_0};
        req_a = 1'b1; we_a = 1'b0; addr_a = 2'd3; sense_a = 4'hC;
        for (int i = 0; i < 5; i++) begin
            step();
            req_a = 1'b0;
            n_cmp++;
            if (obs_a !== exp_v[i]) begin
                $display("[TB] FAIL after_reset_c%0d: got %b expected %b", i + 1, obs_a, exp_v[i]); n_bad++;
            end
        end
        n_cmp++;
        if (rdata_a !== 4'hC) begin
            $display("[TB] FAIL after_reset_rdata: got %h expected c", rdata_a); n_bad++;
        end
    endtask

    task automatic test_params();
        logic [12:0] exp_v [6];
        exp_v = '{13'b1_0000_0_0000_0_1_0, 13'b1_0000_0_0000_0_1_0, 13'b1_0000_0_0000_0_1_0,
                  13'b0_0100_0_0000_1_1_0, 13'b0_0000_0_0000_0_1_1, 13'b0_0000_0_0000_0_0_0};
        req_b = 1'b1; we_b = 1'b0; addr_b = 2'd2; sense_b = 4'h7;
        for (int i = 0; i < 6; i++) begin
            step();
            req_b = 1'b0;
            n_cmp++;
            if (obs_b !== exp_v[i]) begin
                $display("[TB] FAIL params_read_c%0d: got %b expected %b", i + 1, obs_b, exp_v[i]); n_bad++;
            end
            if (i == 4) begin
                n_cmp++;
                if (rdata_b !== 4'h7) begin
                    $display("[TB] FAIL params_rdata: got %h expected 7", rdata_b); n_bad++;
                end
            end
        end
        exp_v = '{13'b1_0000_0_0000_0_1_0, 13'b1_0000_0_0000_0_1_0, 13'b1_0000_0_0000_0_1_0,
                  13'b0_0010_1_1110_0_1_0, 13'b0_0000_0_0000_0_1_1, 13'b0_0000_0_0000_0_0_0};
        req_b = 1'b1; we_b = 1'b1; addr_b = 2'd1; wdata_b = 4'hE; sense_b = 4'h2;
        for (int i = 0; i < 6; i++) begin
            step();
            req_b = 1'b0;
            n_cmp++;
            if (obs_b !== exp_v[i]) begin
                $display("[TB] FAIL params_write_c%0d: got %b expected %b", i + 1, obs_b, exp_v[i]); n_bad++;
            end
        end
        n_cmp++;
        if (rdata_b !== 4'h7) begin
            $display("[TB] FAIL params_rdata_hold: got %h expected 7", rdata_b); n_bad++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_midop();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
